// File: rtl/sram_ctrl.sv
// -----------------------------------------------------------------------------
// sram_ctrl
//
// Single-port controller for the external 16-bit asynchronous frame-buffer
// SRAM. It accepts one word read or write per start/ready handshake from the
// upstream A/B access mux. It sequences the active-low chip-enable,
// output-enable, write-enable and byte-lane strobes through
// SETUP -> ACCESS (WAIT_CYCLES) -> RECOVER.
//
// Parameters
//   WAIT_CYCLES  cycles spent in ACCESS (1..15)
//   ADDR_W       SRAM address pin width (>= 16); upper bits driven 0
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      request, honoured only while ready=1
//   rw         1 = read, 0 = write (sampled at accept)
//   addr       word address (sampled at accept)
//   data_in    write data (sampled at accept)
//   data_out   last read word, held until the next read completes
//   ready      1 = idle and able to accept
//   sram_a     SRAM address
//   sram_dq    SRAM data bus, driven only during writes
//   sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n  SRAM strobes
//
// Configuration macro
//   SRAM_CTRL_FASTREAD_EN  when defined, reads skip RECOVER and return to
//                          IDLE on the capture edge (busy WAIT_CYCLES+1).
// -----------------------------------------------------------------------------
module sram_ctrl #(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              rw,
    input  logic [15:0]       addr,
    input  logic [15:0]       data_in,
    output logic [15:0]       data_out,
    output logic              ready,
    output logic [ADDR_W-1:0] sram_a,
    inout  wire  [15:0]       sram_dq,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              sram_lb_n,
    output logic              sram_ub_n
);

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        SETUP,
        ACCESS,
        RECOVER
    } state_t;

    state_t      state;
    logic [3:0]  wait_cnt;
    logic        rw_q;
    logic [15:0] wdata_q;
    logic        dq_oe;

    // The bus is only ever driven for writes, and oe_n is only ever low for
    // reads, so the two can never overlap.
    assign sram_dq = dq_oe ? wdata_q : 16'bz;

    // All outputs are registered; the async reset returns every strobe high
    // and releases dq immediately, abandoning any transaction in flight.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= INIT;
            ready     <= 1'b0;
            data_out  <= 16'h0000;
            sram_a    <= '0;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            sram_lb_n <= 1'b1;
            sram_ub_n <= 1'b1;
            dq_oe     <= 1'b0;
            wait_cnt  <= '0;
            rw_q      <= 1'b1;
            wdata_q   <= 16'h0000;
        end else begin
            case (state)
                INIT: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end

                // ready is always 1 in IDLE, so start alone is the accept.
                IDLE: begin
                    if (start) begin
                        ready     <= 1'b0;
                        rw_q      <= rw;
                        wdata_q   <= data_in;
                        sram_a    <= ADDR_W'(addr);
                        sram_ce_n <= 1'b0;
                        sram_lb_n <= 1'b0;
                        sram_ub_n <= 1'b0;
                        sram_oe_n <= ~rw;
                        dq_oe     <= ~rw;
                        // Loaded one cycle ahead so ACCESS lasts exactly
                        // WAIT_CYCLES cycles, counting down to 0.
                        wait_cnt  <= 4'(WAIT_CYCLES - 1);
                        state     <= SETUP;
                    end
                end

                // Address/data have had one cycle to settle; open the write.
                SETUP: begin
                    sram_we_n <= rw_q;
                    state     <= ACCESS;
                end

                ACCESS: begin
                    if (wait_cnt == 4'd0) begin
                        sram_we_n <= 1'b1;
                        sram_oe_n <= 1'b1;
                        // oe_n is still low at this edge, so dq is valid.
                        if (rw_q) begin
                            data_out <= sram_dq;
                        end
`ifdef SRAM_CTRL_FASTREAD_EN
                        if (rw_q) begin
                            state     <= IDLE;
                            ready     <= 1'b1;
                            sram_ce_n <= 1'b1;
                            sram_lb_n <= 1'b1;
                            sram_ub_n <= 1'b1;
                        end else begin
                            state <= RECOVER;
                        end
`else
                        state <= RECOVER;
`endif
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end

                // Address, ce_n and write data held one cycle past we_n rise.
                RECOVER: begin
                    state     <= IDLE;
                    ready     <= 1'b1;
                    sram_ce_n <= 1'b1;
                    sram_lb_n <= 1'b1;
                    sram_ub_n <= 1'b1;
                    dq_oe     <= 1'b0;
                end

                default: begin
                    state <= INIT;
                    ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sram_ctrl
//
// Self-checking bench for sram_ctrl: a behavioural asynchronous SRAM on the
// pin side, and a word-array reference model of expected memory contents,
// expected read data and expected busy times.
// -----------------------------------------------------------------------------
module tb_sram_ctrl;

    localparam int W  = 2;
    localparam int AW = 18;
`ifdef SRAM_CTRL_FASTREAD_EN
    localparam int RD_BUSY = W + 1;
`else
    localparam int RD_BUSY = W + 2;
`endif
    localparam int WR_BUSY = W + 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          rw = 1'b0;
    logic [15:0]   addr = 16'h0;
    logic [15:0]   data_in = 16'h0;
    logic [15:0]   data_out;
    logic          ready;
    logic [AW-1:0] sram_a;
    wire  [15:0]   sram_dq;
    logic          sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n;

    sram_ctrl #(.WAIT_CYCLES(W), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .rw        (rw),
        .addr      (addr),
        .data_in   (data_in),
        .data_out  (data_out),
        .ready     (ready),
        .sram_a    (sram_a),
        .sram_dq   (sram_dq),
        .sram_ce_n (sram_ce_n),
        .sram_oe_n (sram_oe_n),
        .sram_we_n (sram_we_n),
        .sram_lb_n (sram_lb_n),
        .sram_ub_n (sram_ub_n)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM device.
    logic [15:0] mem [0:65535];
    assign sram_dq = (!sram_ce_n && !sram_oe_n && sram_we_n) ? mem[sram_a[15:0]] : 16'bz;
    always @(negedge clk) begin
        if (!sram_ce_n && !sram_we_n) mem[sram_a[15:0]] <= sram_dq;
    end

    // Reference model: what memory should contain and what a read should see.
    logic [15:0] ref_mem [logic [15:0]];
    logic [15:0] last_rd = 16'h0000;

    int passed = 0;
    int total  = 0;
    int overlap_err = 0;
    int cyc = 0;
    int acc_q [$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && ready && start) acc_q.push_back(cyc);
    end

    always @(negedge clk) begin
        if (!sram_oe_n && !sram_we_n) overlap_err <= overlap_err + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One handshake; optionally pulses a stray write request while busy.
    task automatic xfer(input logic r, input logic [15:0] a, input logic [15:0] d,
                        input bit inject, output int busy, output int wlow,
                        output logic [15:0] wdq);
        @(negedge clk);
        rw = r; addr = a; data_in = d; start = 1'b1;
        tick();
        start = 1'b0; rw = ~r; addr = ~a; data_in = ~d;
        busy = 0; wlow = 0; wdq = 16'h0;
        while (ready !== 1'b1 && busy < 50) begin
            if (sram_we_n === 1'b0) begin
                wlow++;
                wdq = sram_dq;
            end
            if (inject) begin
                start   = (busy == 1);
                rw      = 1'b0;
                addr    = a;
                data_in = 16'h5555;
            end
            tick();
            busy++;
        end
        start = 1'b0;
    endtask

    task automatic do_op(input logic r, input logic [15:0] a, input logic [15:0] d,
                         input bit inject);
        int busy, wlow;
        logic [15:0] wdq;
        xfer(r, a, d, inject, busy, wlow, wdq);
        if (r) begin
            check("rd_busy", busy, RD_BUSY);
            last_rd = ref_mem.exists(a) ? ref_mem[a] : 16'h0000;
        end else begin
            check("wr_busy", busy, WR_BUSY);
            check("we_low_cycles", wlow, W);
            check("wr_dq", wdq, d);
            ref_mem[a] = d;
        end
        check("data_out", data_out, last_rd);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        logic [15:0] d0, d1;
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;

        // Reset held for 3 cycles.
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_ready", ready, 0);
            check("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n}, 5'b11111);
        end
        check("rst_data_out", data_out, 16'h0000);
        check("rst_sram_a", sram_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready_before_edge", ready, 0);
        tick();
        check("ready_after_release", ready, 1);

        // Directed write then read.
        do_op(1'b0, 16'h1234, 16'hBEEF, 1'b0);
        check("mem_1234", mem[16'h1234], 16'hBEEF);
        do_op(1'b1, 16'h1234, 16'h0000, 1'b0);
        check("rd_beef", data_out, 16'hBEEF);
        check("sram_a_upper", sram_a[AW-1:16], 0);

        // Stray start while busy must be dropped.
        do_op(1'b1, 16'h1234, 16'h0000, 1'b1);
        tick();
        tick();
        check("no_second_txn", ready, 1);
        check("ignored_mem", mem[16'h1234], ref_mem[16'h1234]);

        // Reset during ACCESS of a write.
        @(negedge clk);
        rw = 1'b0; addr = 16'h0042; data_in = 16'h1111; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("midrst_in_access", sram_we_n, 0);
        rst_n = 1'b0;
        #1;
        check("midrst_strobes", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);
        check("midrst_ready", ready, 0);
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("midrst_recover_ready", ready, 1);
        last_rd = 16'h0000;

        // Back-to-back reads from 0 and 1 with start held high.
        d0 = 16'($urandom);
        d1 = 16'($urandom);
        do_op(1'b0, 16'h0000, d0, 1'b0);
        do_op(1'b0, 16'h0001, d1, 1'b0);
        acc_q.delete();
        @(negedge clk);
        rw = 1'b1; addr = 16'h0000; start = 1'b1;
        n = 0;
        while (acc_q.size() < 1 && n < 50) begin tick(); n++; end
        addr = 16'h0001;
        wait_ready();
        check("b2b_rd0", data_out, d0);
        n = 0;
        while (acc_q.size() < 2 && n < 50) begin tick(); n++; end
        start = 1'b0;
        wait_ready();
        check("b2b_rd1", data_out, d1);
        last_rd = d1;
        check("b2b_accepts", acc_q.size(), 2);
        if (acc_q.size() >= 2) check("b2b_spacing", acc_q[1] - acc_q[0], RD_BUSY + 1);

        // Randomised traffic over a small address window.
        for (int i = 0; i < 24; i++) begin
            do_op(1'($urandom_range(0, 1)), 16'h0100 + 16'($urandom_range(0, 7)),
                  16'($urandom), 1'b0);
        end

        check("oe_we_overlap", overlap_err, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Single-port controller for the external 16-bit asynchronous SRAM that holds the frame buffer. It sits directly downstream of the A/B access mux. It accepts one word read or write per start/ready handshake from the mux and generates the SRAM chip-enable, output-enable, write-enable and byte-lane strobes with a programmable number of wait states. Read data is returned to the mux on data_out.

## Interface
- WAIT_CYCLES, 2: cycles in ACCESS state; legal range 1..15.
- ADDR_W, 16: SRAM address pin width; legal range ≥16. Upper ADDR_W-16 bits are driven 0.

- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request; sampled only while ready=1.
- rw  in  1  1 = read, 0 = write; sampled at accept.
- addr  in  16  word address; sampled at accept.
- data_in  in  16  write data; sampled at accept.
- data_out  out  16  last read word, registered; held until the next read completes.
- ready  out  1  1 = idle and able to accept; registered.
- sram_a  out  ADDR_W  SRAM address.
- sram_dq  inout  16  SRAM data; driven only during writes.
- sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n  out  1 each  active-low SRAM strobes.

## Operation
- States: INIT, IDLE, SETUP, ACCESS, RECOVER.
- Accept: state=IDLE, ready=1 and start=1 at a rising edge.
  - Latch rw, addr and data_in into internal registers.
  - Go to SETUP. ready=0 from that edge.
- INIT -> IDLE unconditionally on the first edge after reset release.
- IDLE -> SETUP on accept; otherwise stay in IDLE.
- SETUP (1 cycle):
  - sram_a = latched addr; ce_n=lb_n=ub_n=0.
  - Read: oe_n=0.
  - Write: oe_n=1 and sram_dq driven with the latched data; we_n stays 1.
  - Load the wait counter with WAIT_CYCLES-1. Go to ACCESS.
- ACCESS (WAIT_CYCLES cycles):
  - Write: we_n=0.
  - Counter decrements each cycle. At count 0, go to RECOVER.
  - Read: sram_dq is captured into data_out on the ACCESS->RECOVER edge.
- RECOVER (1 cycle):
  - we_n=1 and oe_n=1.
  - Write: address, ce_n and dq are still driven (hold time).
  - Go to IDLE and set ready=1 on the exit edge.
- IDLE: ce_n=oe_n=we_n=lb_n=ub_n=1; sram_dq tri-stated; sram_a holds its last value.
- start while ready=0 is ignored and is not queued.
- Changes to rw, addr or data_in after accept have no effect on the transaction in flight.
- Write transactions never modify data_out.
- sram_dq is never driven while oe_n=0.
- The upstream mux changes select only while ready=1. The controller does not check this.

## Timing
- Reset values, asynchronous:
  - state=INIT, ready=0, data_out=16'h0000, sram_a=0.
  - All SRAM strobes 1; sram_dq high-Z.
- Reset asserted mid-transaction: the strobes go high and dq releases immediately, without waiting for clk. The transaction is lost.
- ready=1 on the first rising edge after rst_n deasserts.
- Accept at edge E0 gives this sequence:
  - SETUP during E0..E1.
  - ACCESS during E1..E1+WAIT_CYCLES.
  - RECOVER for the following cycle.
  - ready=1 after edge E0+WAIT_CYCLES+2.
- Busy time: ready=0 for WAIT_CYCLES+2 cycles. With the default, ready is low for 4 cycles.
- Back-to-back: start held high gives one accept every WAIT_CYCLES+3 cycles (one IDLE cycle between transactions).
- Read data is valid on data_out in the same cycle that ready rises.
- Write: we_n is low for exactly WAIT_CYCLES cycles. Address and data are stable 1 cycle before we_n falls and 1 cycle after it rises.

## Configuration
- Macro: SRAM_CTRL_FASTREAD_EN.
- Defined: reads skip RECOVER.
  - ACCESS -> IDLE directly and ready=1 on the capture edge.
  - Read busy time becomes WAIT_CYCLES+1.
  - Writes are unchanged.
- Undefined: reads and writes both pass through RECOVER, as described above.

## Test plan
- Reset release: hold rst_n=0 for 3 cycles, then release. ready=0 during reset and becomes 1 one edge after release. Strobes stay 1 throughout and data_out=0000.
- Write then read, WAIT_CYCLES=2:
  - Write addr 16'h1234, data 16'hBEEF. we_n is low for exactly 2 cycles with dq=BEEF.
  - Read addr 16'h1234. data_out=BEEF when ready rises, 4 cycles after accept.
- Ignored start: pulse start with rw=0 and data 16'h5555 while ready=0 during a read. No second transaction occurs and the SRAM model is unchanged.
- Mid-transaction reset: assert rst_n=0 during the ACCESS state of a write. we_n, ce_n and oe_n go to 1 and dq goes high-Z within the same cycle, asynchronously. After release, ready returns to 1.
- Back-to-back reads from addresses 0 and 1 with start held high:
  - Accepts are 5 cycles apart.
  - data_out updates to each stored word in turn.
  - oe_n and a driven dq never overlap.
- SRAM_CTRL_FASTREAD_EN defined: a read returns ready in 3 cycles; a write still takes 4 cycles.
